// File: rtl/bpu_pkg.sv
// Shared constants, encodings and the 2-bit saturating counter helper for the
// dynamic branch predictor.
package bpu_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bht_state_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      if (ctr == CTR_ST) begin
        nxt = CTR_ST;
      end else begin
        nxt = ctr + 2'd1;
      end
    end else begin
      if (ctr == CTR_SNT) begin
        nxt = CTR_SNT;
      end else begin
        nxt = ctr - 2'd1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bpu_dyn_if.sv
// IF-side prediction and ID-side training signals between the hart and the
// dynamic branch predictor.
interface bpu_dyn_if #(
  parameter int XLEN  = 64,
  parameter int IDX_W = 8
);

  logic [XLEN-1:0]  pc;
  logic [31:0]      ir;
  logic             jal_taken;
  logic [XLEN-1:0]  jal_addr;
  logic             pr_taken;
  logic [12:0]      pr_offs;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_mispred;
  logic             init_busy;
  logic [31:0]      cnt_mispred;

  modport master (
    output pc, ir, upd_valid, upd_idx, upd_taken, upd_mispred,
    input  jal_taken, jal_addr, pr_taken, pr_offs, pred_idx, init_busy, cnt_mispred
  );

  modport slave (
    input  pc, ir, upd_valid, upd_idx, upd_taken, upd_mispred,
    output jal_taken, jal_addr, pr_taken, pr_offs, pred_idx, init_busy, cnt_mispred
  );

endinterface

// File: rtl/bht_table.sv
// Counter table with asynchronous read, synchronous training write and the
// post-reset sweep that loads every entry with CTR_INIT.
module bht_table #(
  parameter int         ENTRIES  = 256,
  parameter int         IDX_W    = 8,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken,
  output logic             init_busy
);
  import bpu_pkg::*;

  bht_state_e       state_r;
  logic [IDX_W-1:0] sweep_r;
  logic             busy_r;
  logic [1:0]       ctr_tbl_r [ENTRIES];

  // Sweep sequencer; leaves INIT only after the last entry has been written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_INIT;
      sweep_r <= '0;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (sweep_r == IDX_W'(ENTRIES - 1)) begin
            state_r <= ST_RUN;
            sweep_r <= '0;
            busy_r  <= 1'b0;
          end else begin
            sweep_r <= sweep_r + {{(IDX_W-1){1'b0}}, 1'b1};
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          busy_r <= 1'b0;
        end
        default: begin
          state_r <= ST_INIT;
          sweep_r <= '0;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Single write port shared by the sweep and training; training is ignored while sweeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == ST_INIT) begin
        ctr_tbl_r[sweep_r] <= CTR_INIT;
      end else if (wr_en) begin
        ctr_tbl_r[wr_idx] <= ctr_next(ctr_tbl_r[wr_idx], wr_taken);
      end
    end
  end

  assign rd_ctr    = ctr_tbl_r[rd_idx];
  assign init_busy = busy_r;

endmodule

// File: rtl/bpu_dyn.sv
// Dynamic branch prediction unit: IF-side decode and prediction, bimodal or
// gshare indexing, resolved-branch history and mispredict counter.
module bpu_dyn #(
  parameter int         XLEN      = 64,
  parameter int         ENTRIES   = 256,
  parameter int         MODE      = 0,
  parameter int         HIST_BITS = 8,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic      clk,
  input  logic      rst,
  bpu_dyn_if.slave  bus
);
  import bpu_pkg::*;

  localparam int IDX_W = $clog2(ENTRIES);

  logic                 is_branch_s;
  logic [20:0]          jal_imm_s;
  logic [IDX_W-1:0]     idx_s;
  logic [1:0]           rd_ctr_s;
  logic                 busy_s;
  logic [HIST_BITS-1:0] ghr_r;
  logic [31:0]          cnt_r;

  // Instruction decode for JAL target and B-type offset.
  always_comb begin
    is_branch_s   = (bus.ir[6:0] == OP_BRANCH);
    bus.jal_taken = (bus.ir[6:0] == OP_JAL);
    jal_imm_s     = {bus.ir[31], bus.ir[19:12], bus.ir[20], bus.ir[30:21], 1'b0};
    bus.jal_addr  = bus.pc + {{(XLEN-21){jal_imm_s[20]}}, jal_imm_s};
    if (is_branch_s) begin
      bus.pr_offs = {bus.ir[31], bus.ir[7], bus.ir[30:25], bus.ir[11:8], 1'b0};
    end else begin
      bus.pr_offs = 13'd0;
    end
  end

  // Table index: word-aligned PC bits, folded with history in gshare builds.
  always_comb begin
    if (MODE == MODE_GSHARE) begin
      idx_s = bus.pc[IDX_W+1:2] ^ IDX_W'(ghr_r);
    end else begin
      idx_s = bus.pc[IDX_W+1:2];
    end
  end

  bht_table #(
    .ENTRIES  (ENTRIES),
    .IDX_W    (IDX_W),
    .CTR_INIT (CTR_INIT)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (idx_s),
    .rd_ctr    (rd_ctr_s),
    .wr_en     (bus.upd_valid),
    .wr_idx    (bus.upd_idx),
    .wr_taken  (bus.upd_taken),
    .init_busy (busy_s)
  );

  assign bus.pred_idx    = idx_s;
  assign bus.pr_taken    = is_branch_s & rd_ctr_s[1] & ~busy_s;
  assign bus.init_busy   = busy_s;
  assign bus.cnt_mispred = cnt_r;

  // History and mispredict count advance only on resolves outside the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_r <= '0;
      cnt_r <= 32'd0;
    end else if (bus.upd_valid && !busy_s) begin
      if (MODE == MODE_GSHARE) begin
        ghr_r <= (ghr_r << 1) | HIST_BITS'(bus.upd_taken);
      end else begin
        ghr_r <= ghr_r;
      end
      if (bus.upd_mispred && (cnt_r != 32'hFFFF_FFFF)) begin
        cnt_r <= cnt_r + 32'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      ghr_r <= ghr_r;
      cnt_r <= cnt_r;
    end
  end

endmodule
